// File: rtl/mips_pkg.sv
// Shared definitions for the register-file write-back path.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } wb_sched_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for MDU destinations plus the decode hazard compares.
module regfile_scoreboard
  import mips_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_set,
  input  logic [REG_ADDR_W-1:0] i_set_dst,
  input  logic                  i_clr,
  input  logic [REG_ADDR_W-1:0] i_clr_dst,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic [REG_ADDR_W-1:0] i_id_dst,
  input  logic                  i_id_dst_valid,
  output logic                  o_stall,
  output logic [NUM_REGS-1:0]   o_pending
);

  logic [NUM_REGS-1:0] pending_q, pending_d;

  // The set is applied after the clear so a same-cycle reissue keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (i_clr) pending_d[i_clr_dst] = 1'b0;
    if (i_set) pending_d[i_set_dst] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  assign o_stall   = pending_q[i_id_rs] | pending_q[i_id_rt] |
                     (i_id_dst_valid & pending_q[i_id_dst]);
  assign o_pending = pending_q;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port between WB and the MDU,
// and raises a pipeline hold when MDU results are starved for too long.
module regfile_wb_scheduler
  import mips_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wb_valid,
  input  logic [REG_ADDR_W-1:0] i_wb_dst,
  input  logic [DATA_W-1:0]     i_wb_data,
  input  logic                  i_mdu_valid,
  output logic                  o_mdu_ready,
  input  logic [REG_ADDR_W-1:0] i_mdu_dst,
  input  logic [DATA_W-1:0]     i_mdu_data,
  input  logic                  i_mdu_issue,
  input  logic [REG_ADDR_W-1:0] i_mdu_issue_dst,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic [REG_ADDR_W-1:0] i_id_dst,
  input  logic                  i_id_dst_valid,
  output logic                  o_id_stall,
  output logic                  o_pipe_hold,
  output logic [REG_ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0]     o_wr_data,
  output logic [NUM_REGS-1:0]   o_pending
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  wb_sched_state_t state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [REG_ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [DATA_W-1:0] wrData_q, wrData_d;

  logic wbEffective, mduAccept, mduBlocked;

  assign wbEffective = i_wb_valid && (i_wb_dst != '0);
  assign o_mdu_ready = !wbEffective;
  assign mduAccept   = i_mdu_valid && o_mdu_ready;
  assign mduBlocked  = i_mdu_valid && !o_mdu_ready;

  // Idle cycles and r0-destined MDU results write zero to r0.
  always_comb begin
    wrAddr_d = '0;
    wrData_d = '0;
    if (wbEffective) begin
      wrAddr_d = i_wb_dst;
      wrData_d = i_wb_data;
    end else if (mduAccept && (i_mdu_dst != '0)) begin
      wrAddr_d = i_mdu_dst;
      wrData_d = i_mdu_data;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (mduBlocked) begin
          count_d = CNT_W'(1);
          state_d = (STARVE_LIMIT <= 1) ? HOLD : WAIT;
        end
      end
      WAIT: begin
        if (mduAccept || !i_mdu_valid) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
          if (count_d == LIMIT_C) state_d = HOLD;
        end
      end
      HOLD: begin
        if (mduAccept) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wrAddr_q <= '0;
      wrData_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
    end
  end

  assign o_pipe_hold = (state_q == HOLD);
  assign o_wr_addr   = wrAddr_q;
  assign o_wr_data   = wrData_q;

  regfile_scoreboard u_scoreboard (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_set          (i_mdu_issue && (i_mdu_issue_dst != '0)),
    .i_set_dst      (i_mdu_issue_dst),
    .i_clr          (mduAccept),
    .i_clr_dst      (i_mdu_dst),
    .i_id_rs        (i_id_rs),
    .i_id_rt        (i_id_rt),
    .i_id_dst       (i_id_dst),
    .i_id_dst_valid (i_id_dst_valid),
    .o_stall        (o_id_stall),
    .o_pending      (o_pending)
  );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench: directed scenarios plus a protocol-respecting random run,
// compared every cycle against a behavioural model of the write-port scheduler.
module tb_regfile_wb_scheduler;

  localparam int STARVE_LIMIT = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_wb_valid;
  logic [4:0]  i_wb_dst;
  logic [31:0] i_wb_data;
  logic        i_mdu_valid;
  logic        o_mdu_ready;
  logic [4:0]  i_mdu_dst;
  logic [31:0] i_mdu_data;
  logic        i_mdu_issue;
  logic [4:0]  i_mdu_issue_dst;
  logic [4:0]  i_id_rs, i_id_rt, i_id_dst;
  logic        i_id_dst_valid;
  logic        o_id_stall, o_pipe_hold;
  logic [4:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic [31:0] o_pending;

  int compared   = 0;
  int mismatched = 0;
  bit started    = 1'b0;

  bit [31:0] mPend;
  bit [4:0]  mAddr;
  bit [31:0] mData;
  int        mRun;
  bit        mHold;

  always #5 i_clk = ~i_clk;

  regfile_wb_scheduler #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_wb_valid      (i_wb_valid),
    .i_wb_dst        (i_wb_dst),
    .i_wb_data       (i_wb_data),
    .i_mdu_valid     (i_mdu_valid),
    .o_mdu_ready     (o_mdu_ready),
    .i_mdu_dst       (i_mdu_dst),
    .i_mdu_data      (i_mdu_data),
    .i_mdu_issue     (i_mdu_issue),
    .i_mdu_issue_dst (i_mdu_issue_dst),
    .i_id_rs         (i_id_rs),
    .i_id_rt         (i_id_rt),
    .i_id_dst        (i_id_dst),
    .i_id_dst_valid  (i_id_dst_valid),
    .o_id_stall      (o_id_stall),
    .o_pipe_hold     (o_pipe_hold),
    .o_wr_addr       (o_wr_addr),
    .o_wr_data       (o_wr_data),
    .o_pending       (o_pending)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: WB wins when effective, otherwise an offered MDU result is taken;
  // hold rises after STARVE_LIMIT consecutive blocked cycles and falls on accept.
  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mPend = '0; mAddr = '0; mData = '0; mRun = 0; mHold = 1'b0;
    end else begin
      bit wbEff, acc, blk;
      wbEff = i_wb_valid && (i_wb_dst != 0);
      acc   = i_mdu_valid && !wbEff;
      blk   = i_mdu_valid && wbEff;
      if (wbEff) begin
        mAddr = i_wb_dst; mData = i_wb_data;
      end else if (acc && i_mdu_dst != 0) begin
        mAddr = i_mdu_dst; mData = i_mdu_data;
      end else begin
        mAddr = '0; mData = '0;
      end
      if (acc) mPend[i_mdu_dst] = 1'b0;
      if (i_mdu_issue && i_mdu_issue_dst != 0) mPend[i_mdu_issue_dst] = 1'b1;
      mPend[0] = 1'b0;
      if (acc) begin
        mRun = 0; mHold = 1'b0;
      end else if (blk) begin
        mRun++;
        if (mRun >= STARVE_LIMIT) mHold = 1'b1;
      end else if (!mHold) begin
        mRun = 0;
      end
    end
  end

  always @(negedge i_clk) begin
    if (started) begin
      checkOutput("mdu_ready", {31'b0, o_mdu_ready}, {31'b0, !(i_wb_valid && i_wb_dst != 0)});
      checkOutput("id_stall", {31'b0, o_id_stall},
                  {31'b0, mPend[i_id_rs] | mPend[i_id_rt] | (i_id_dst_valid & mPend[i_id_dst])});
      checkOutput("wr_addr", {27'b0, o_wr_addr}, {27'b0, mAddr});
      checkOutput("wr_data", o_wr_data, mData);
      checkOutput("pending", o_pending, mPend);
      checkOutput("pipe_hold", {31'b0, o_pipe_hold}, {31'b0, mHold});
    end
  end

  task automatic applyStimulus(input bit wbV, input bit [4:0] wbDst, input bit [31:0] wbData,
                               input bit mduV, input bit [4:0] mduDst, input bit [31:0] mduData,
                               input bit iss, input bit [4:0] issDst);
    i_wb_valid = wbV; i_wb_dst = wbDst; i_wb_data = wbData;
    i_mdu_valid = mduV; i_mdu_dst = mduDst; i_mdu_data = mduData;
    i_mdu_issue = iss; i_mdu_issue_dst = issDst;
  endtask

  task automatic setDecode(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] dst, input bit dv);
    i_id_rs = rs; i_id_rt = rt; i_id_dst = dst; i_id_dst_valid = dv;
  endtask

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    i_reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    setDecode(0, 0, 0, 0);
    #2 i_reset = 1'b1;
    started = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;

    idle(3);
    checkOutput("lit_reset_addr", {27'b0, o_wr_addr}, 32'h0);
    checkOutput("lit_reset_data", o_wr_data, 32'h0);
    checkOutput("lit_reset_pend", o_pending, 32'h0);
    checkOutput("lit_reset_ready", {31'b0, o_mdu_ready}, 32'h1);
    checkOutput("lit_reset_hold", {31'b0, o_pipe_hold}, 32'h0);

    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cycle();
    checkOutput("lit_wb_addr", {27'b0, o_wr_addr}, 32'd5);
    checkOutput("lit_wb_data", o_wr_data, 32'hDEADBEEF);
    idle(1);
    checkOutput("lit_idle_addr", {27'b0, o_wr_addr}, 32'd0);

    // MDU colliding with WB is deferred, then written in the next free cycle.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
    cycle();
    checkOutput("lit_pend9", o_pending, 32'h0000_0200);
    applyStimulus(1, 3, 32'h0000_AAAA, 1, 9, 32'h1234, 0, 0);
    #1 checkOutput("lit_ready_low", {31'b0, o_mdu_ready}, 32'h0);
    cycle();
    checkOutput("lit_wb3_addr", {27'b0, o_wr_addr}, 32'd3);
    checkOutput("lit_wb3_data", o_wr_data, 32'h0000_AAAA);
    applyStimulus(0, 0, 0, 1, 9, 32'h1234, 0, 0);
    #1 checkOutput("lit_ready_high", {31'b0, o_mdu_ready}, 32'h1);
    cycle();
    checkOutput("lit_mdu9_addr", {27'b0, o_wr_addr}, 32'd9);
    checkOutput("lit_mdu9_data", o_wr_data, 32'h1234);
    checkOutput("lit_pend9_clr", o_pending, 32'h0);
    idle(1);

    // RAW / WAW stalls against an outstanding MDU destination.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 12);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    setDecode(12, 0, 0, 0);
    #1 checkOutput("lit_raw_stall", {31'b0, o_id_stall}, 32'h1);
    setDecode(0, 0, 12, 1);
    #1 checkOutput("lit_waw_stall", {31'b0, o_id_stall}, 32'h1);
    setDecode(0, 0, 12, 0);
    #1 checkOutput("lit_no_stall", {31'b0, o_id_stall}, 32'h0);
    setDecode(12, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 12, 32'hCAFE, 0, 0);
    #1 checkOutput("lit_stall_accept", {31'b0, o_id_stall}, 32'h1);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("lit_stall_gone", {31'b0, o_id_stall}, 32'h0);
    setDecode(0, 0, 0, 0);
    idle(1);

    // Starvation: four blocked cycles raise the hold; WB still wins during it.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 20);
    cycle();
    for (int k = 1; k <= STARVE_LIMIT + 1; k++) begin
      applyStimulus(1, 4, 32'h100 + k, 1, 20, 32'h55, 0, 0);
      cycle();
      if (k == STARVE_LIMIT - 1) checkOutput("lit_hold_before", {31'b0, o_pipe_hold}, 32'h0);
      if (k == STARVE_LIMIT) checkOutput("lit_hold_set", {31'b0, o_pipe_hold}, 32'h1);
    end
    checkOutput("lit_hold_wb_addr", {27'b0, o_wr_addr}, 32'd4);
    checkOutput("lit_hold_kept", {31'b0, o_pipe_hold}, 32'h1);
    applyStimulus(0, 0, 0, 1, 20, 32'h55, 0, 0);
    cycle();
    checkOutput("lit_hold_clr", {31'b0, o_pipe_hold}, 32'h0);
    checkOutput("lit_starved_addr", {27'b0, o_wr_addr}, 32'd20);
    idle(1);

    // Same-cycle reissue keeps the pending bit.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
    cycle();
    applyStimulus(0, 0, 0, 1, 7, 32'h77, 1, 7);
    cycle();
    checkOutput("lit_set_wins", o_pending, 32'h0000_0080);

    // Reset mid-operation while pending and held.
    for (int k = 0; k < STARVE_LIMIT; k++) begin
      applyStimulus(1, 4, 32'h999, 1, 7, 32'h77, 0, 0);
      cycle();
    end
    checkOutput("lit_pre_reset_hold", {31'b0, o_pipe_hold}, 32'h1);
    i_reset = 1'b1;
    #1;
    checkOutput("lit_rst_addr", {27'b0, o_wr_addr}, 32'h0);
    checkOutput("lit_rst_data", o_wr_data, 32'h0);
    checkOutput("lit_rst_pend", o_pending, 32'h0);
    checkOutput("lit_rst_hold", {31'b0, o_pipe_hold}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    i_reset = 1'b0;
    idle(1);

    // r0 destinations: MDU consumed as zero write, WB to r0 is not effective.
    applyStimulus(0, 0, 0, 1, 0, 32'hFFFF, 0, 0);
    cycle();
    checkOutput("lit_mdu_r0_data", o_wr_data, 32'h0);
    applyStimulus(1, 0, 32'h1111, 1, 9, 32'h4444, 0, 0);
    #1 checkOutput("lit_wb_r0_ready", {31'b0, o_mdu_ready}, 32'h1);
    cycle();
    checkOutput("lit_wb_r0_addr", {27'b0, o_wr_addr}, 32'd9);
    idle(1);

    // Random traffic; a blocked MDU keeps its offer stable.
    for (int n = 0; n < 400; n++) begin
      bit blocked;
      bit [4:0] mDst;
      bit [31:0] mDat;
      bit mV;
      blocked = i_mdu_valid && i_wb_valid && (i_wb_dst != 0);
      mV = blocked ? 1'b1 : ($urandom_range(0, 1) == 1);
      mDst = blocked ? i_mdu_dst : 5'($urandom_range(0, 31));
      mDat = blocked ? i_mdu_data : $urandom;
      applyStimulus($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
                    mV, mDst, mDat, $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)));
      setDecode(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1);
      cycle();
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Schedules the single write port of the 32x32 register file between the in-order pipeline write-back stage and the multi-cycle multiply/divide unit (MDU), which returns results out of band. It tracks outstanding MDU destinations in a scoreboard and stalls decode on RAW/WAW hazards against them. It also requests a pipeline hold when an MDU result is starved. It sits between the WB stage, the MDU and the register file, and drives the register file's write address and write data.

## Interface
- STARVE_LIMIT, 4: consecutive blocked MDU cycles before a hold is requested; legal range ≥1.
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_wb_valid  in  1  pipeline WB result present this cycle.
- i_wb_dst  in  5  WB destination register.
- i_wb_data  in  32  WB result.
- i_mdu_valid  in  1  MDU result offered.
- o_mdu_ready  out  1  MDU result accepted this cycle.
- i_mdu_dst  in  5  MDU result destination.
- i_mdu_data  in  32  MDU result.
- i_mdu_issue  in  1  MDU op issued from decode this cycle.
- i_mdu_issue_dst  in  5  destination of the issued MDU op.
- i_id_rs, i_id_rt  in  5 each  decode source registers.
- i_id_dst  in  5  decode destination register.
- i_id_dst_valid  in  1  decode instruction writes a register.
- o_id_stall  out  1  decode must stall.
- o_pipe_hold  out  1  pipeline must not present a WB result next cycle.
- o_wr_addr  out  5  register file write address.
- o_wr_data  out  32  register file write data.
- o_pending  out  32  scoreboard bits, for debug.

## Operation
- The register file writes every cycle and has no write enable. On an idle cycle the block drives o_wr_addr=0 and o_wr_data=0, which keeps r0 at zero.
- A WB request is effective only when i_wb_valid=1 and i_wb_dst≠0.
- Priority: an effective WB always wins, because WB cannot be back-pressured.
- o_mdu_ready is combinational: o_mdu_ready = !(effective WB).
- MDU handshake:
  - A transfer occurs when i_mdu_valid and o_mdu_ready are both high.
  - While i_mdu_valid=1 and o_mdu_ready=0, the MDU holds i_mdu_dst and i_mdu_data stable.
  - An accepted MDU result with dst=0 is consumed but written as addr 0, data 0.
- Scoreboard:
  - i_mdu_issue with a nonzero destination sets pending[dst].
  - An accepted MDU transfer clears pending[i_mdu_dst].
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - pending[0] is always 0.
- o_id_stall is combinational. It is asserted when pending[i_id_rs], pending[i_id_rt], or (i_id_dst_valid and pending[i_id_dst]) is set.
  - Because the stall covers WAW, an issue to an already-pending destination never occurs legally. If it does occur, the bit simply stays set.
- Starvation FSM. Counter width is clog2(STARVE_LIMIT+1). The counter saturates.
  - IDLE: counter=0, o_pipe_hold=0. Go to WAIT when i_mdu_valid=1 and not accepted.
  - WAIT: counter increments on each blocked cycle. Go to IDLE on accept, or when i_mdu_valid drops. Go to HOLD when the counter reaches STARVE_LIMIT.
  - HOLD: o_pipe_hold=1 (registered). Go to IDLE on accept. If an effective WB still arrives, WB still wins and the FSM stays in HOLD.

## Timing
- Write port outputs are registered, with 1-cycle latency: the winner at edge N appears on o_wr_addr/o_wr_data after edge N and is written at edge N+1.
- Reset values:
  - o_wr_addr=0, o_wr_data=0.
  - pending=0.
  - FSM state IDLE, counter=0.
  - o_pipe_hold=0.
  - o_id_stall and o_mdu_ready follow the inputs combinationally (with pending=0: stall=0).
- Reset asserted mid-operation discards any in-flight MDU offer and all pending bits. The MDU is reset by the same signal.
- The scoreboard clear takes effect at the acceptance edge. Decode may stop stalling on the following cycle, when the write is registered. Register-file bypass of the in-flight write is the forwarding unit's responsibility.

## Structure
- Shared package (mips_pkg):
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32.
  - The wb_sched_state_t enum: IDLE, WAIT, HOLD.
- Sub-module regfile_scoreboard contains the pending bits with set/clear/set-wins logic and the three hazard compares. The top level holds the FSM, the arbitration and the output registers.

## Test plan
- Reset, then idle 3 cycles → o_wr_addr=0, o_wr_data=0, o_pending=0, o_mdu_ready=1, o_pipe_hold=0.
- WB dst=5, data=0xDEADBEEF with the MDU idle → next cycle o_wr_addr=5, o_wr_data=0xDEADBEEF.
- MDU valid dst=9 data=0x1234 together with WB dst=3 → o_mdu_ready=0 and WB is written first. In the following WB-free cycle the MDU is accepted, then addr=9 is written and pending[9] clears.
- Issue MDU dst=12, then decode rs=12 → o_id_stall=1 until acceptance. Decode dst=12 stalls likewise (WAW). Decode rs=0 never stalls.
- With STARVE_LIMIT=4, MDU valid blocked by WB for 4 consecutive cycles → o_pipe_hold=1 from the next cycle. When WB drops, the MDU is accepted and o_pipe_hold returns to 0.
- Issue dst=7 in the same cycle as acceptance of an older dst=7 → pending[7] remains 1. Assert i_reset while an MDU is pending → all outputs return to reset values immediately.
